// File: rtl/mips_fetch_sequencer.sv
// Handshaked instruction-fetch engine: assembles BEATS memory beats into one
// instruction word, tolerates wait states and flags a per-beat timeout.
module mips_fetch_sequencer #(
  parameter int unsigned AWIDTH   = 8,
  parameter int unsigned DWIDTH   = 8,
  parameter int unsigned BEATS    = 4,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [AWIDTH-1:0]         pc,
  input  logic [DWIDTH-1:0]         mem_rdata,
  input  logic                      mem_valid,
  output logic                      mem_req,
  output logic [AWIDTH-1:0]         mem_addr,
  output logic [BEATS*DWIDTH-1:0]   instr,
  output logic                      instr_valid,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int unsigned IW = BEATS * DWIDTH;
  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [BW-1:0] LAST_BEAT  = BW'(BEATS - 1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] base_q, base_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [IW-1:0]     instr_q, instr_d;
  logic              mem_req_q, mem_req_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic              instr_valid_q, instr_valid_d;
  logic              busy_q, busy_d;
  logic              timeout_err_q, timeout_err_d;

  // Next-state, datapath and next-cycle output decode.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    instr_d = instr_q;

    case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d = S_FETCH;
          base_d  = pc;
          beat_d  = '0;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        if (mem_valid) begin
          instr_d[beat_q*DWIDTH +: DWIDTH] = mem_rdata;
          wait_d = '0;
          if (beat_q == LAST_BEAT) begin
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else if (MAX_WAIT != 0) begin
          wait_d = wait_q + WW'(1);
          if (wait_q == WAIT_LIMIT) begin
            state_d = S_ERR;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the state.
    mem_req_d     = (state_d == S_FETCH);
    mem_addr_d    = base_d + AWIDTH'(beat_d);
    instr_valid_d = (state_d == S_DONE);
    busy_d        = (state_d == S_FETCH) || (state_d == S_DONE);
    timeout_err_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      beat_q        <= '0;
      wait_q        <= '0;
      instr_q       <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      beat_q        <= beat_d;
      wait_q        <= wait_d;
      instr_q       <= instr_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      instr_valid_q <= instr_valid_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// Directed bench for mips_fetch_sequencer: vector table for the basic fetch
// flows plus hand sequences for timeout, reset abort and a 2x16 build.
module tb_mips_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  pc;
  logic [7:0]  mem_rdata;
  logic        mem_valid;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        busy;
  logic        timeout_err;

  logic        start2;
  logic [7:0]  pc2;
  logic [15:0] rdata2;
  logic        valid2;
  logic        req2;
  logic [7:0]  addr2;
  logic [31:0] instr2;
  logic        iv2;
  logic        busy2;
  logic        err2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_fetch_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_req(mem_req),
    .mem_addr(mem_addr), .instr(instr), .instr_valid(instr_valid),
    .busy(busy), .timeout_err(timeout_err)
  );

  mips_fetch_sequencer #(.AWIDTH(8), .DWIDTH(16), .BEATS(2), .MAX_WAIT(15)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .pc(pc2),
    .mem_rdata(rdata2), .mem_valid(valid2), .mem_req(req2),
    .mem_addr(addr2), .instr(instr2), .instr_valid(iv2),
    .busy(busy2), .timeout_err(err2)
  );

  typedef struct {
    logic        start;
    logic [7:0]  pc;
    logic [7:0]  rdata;
    logic        valid;
    logic        e_req;
    logic [7:0]  e_addr;
    logic        c_addr;
    logic        e_iv;
    logic        e_busy;
    logic        e_err;
    logic [31:0] e_instr;
    logic        c_instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic st, input logic [7:0] p, input logic [7:0] rd,
                              input logic v, input logic rq, input logic [7:0] ad,
                              input logic ca, input logic iv, input logic bz,
                              input logic er, input logic [31:0] ins, input logic ci);
    vec_t r;
    r.start = st; r.pc = p; r.rdata = rd; r.valid = v;
    r.e_req = rq; r.e_addr = ad; r.c_addr = ca; r.e_iv = iv;
    r.e_busy = bz; r.e_err = er; r.e_instr = ins; r.c_instr = ci;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string tag, input logic rq, input logic iv,
                         input logic bz, input logic er);
    chk({tag, ".mem_req"}, 32'(mem_req), 32'(rq));
    chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(iv));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(er));
  endtask

  // Feed four zero-wait beats of word starting in the first FETCH cycle, then check DONE and IDLE.
  task automatic feed4(input string tag, input logic [7:0] base, input logic [31:0] word);
    for (int b = 0; b < 4; b++) begin
      mem_rdata = word[b*8 +: 8];
      mem_valid = 1'b1;
      chk({tag, ".addr"}, 32'(mem_addr), 32'(8'(base + 8'(b))));
      chk_ctl(tag, 1'b1, 1'b0, 1'b1, 1'b0);
      step();
    end
    mem_valid = 1'b0;
    chk_ctl({tag, ".done"}, 1'b0, 1'b1, 1'b1, 1'b0);
    chk({tag, ".instr"}, instr, word);
    step();
    chk_ctl({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; pc = '0; mem_rdata = '0; mem_valid = 1'b0;
    start2 = 1'b0; pc2 = '0; rdata2 = '0; valid2 = 1'b0;

    // Zero-wait fetch at 0x10, stray mem_valid in IDLE.
    vecs.push_back(mk(1, 8'h10, 8'h00, 0, 0, 8'h00, 1, 0, 0, 0, 32'h0, 1));
    vecs.push_back(mk(0, 8'h00, 8'h78, 1, 1, 8'h10, 1, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h56, 1, 1, 8'h11, 1, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h34, 1, 1, 8'h12, 1, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h12, 1, 1, 8'h13, 1, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 32'h12345678, 1));
    vecs.push_back(mk(0, 8'h00, 8'hFF, 1, 0, 8'h00, 0, 0, 0, 0, 32'h12345678, 1));
    // Three wait states before beat 2.
    vecs.push_back(mk(1, 8'h40, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 32'h12345678, 1));
    vecs.push_back(mk(0, 8'h00, 8'hAB, 1, 1, 8'h40, 1, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 8'h00, 8'hCD, 1, 1, 8'h41, 1, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 8'h00, 8'hEE, 0, 1, 8'h42, 1, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 8'h00, 8'hEE, 0, 1, 8'h42, 1, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 8'h00, 8'hEE, 0, 1, 8'h42, 1, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 8'h00, 8'hEF, 1, 1, 8'h42, 1, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h01, 1, 1, 8'h43, 1, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 32'h01EFCDAB, 1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 32'h01EFCDAB, 1));
    // Address wrap from 0xFE; start during DONE is ignored and IDLE holds.
    vecs.push_back(mk(1, 8'hFE, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 32'h01EFCDAB, 1));
    vecs.push_back(mk(0, 8'h00, 8'hD1, 1, 1, 8'hFE, 1, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 8'h00, 8'hD2, 1, 1, 8'hFF, 1, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 8'h00, 8'hD3, 1, 1, 8'h00, 1, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(0, 8'h00, 8'hD4, 1, 1, 8'h01, 1, 0, 1, 0, 32'h0, 0));
    vecs.push_back(mk(1, 8'h33, 8'h00, 0, 0, 8'h00, 0, 1, 1, 0, 32'hD4D3D2D1, 1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 32'hD4D3D2D1, 1));
    vecs.push_back(mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0, 0, 32'hD4D3D2D1, 1));

    step();
    step();
    chk_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset.addr", 32'(mem_addr), 32'h0);
    chk("reset.instr", instr, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      start     = vecs[i].start;
      pc        = vecs[i].pc;
      mem_rdata = vecs[i].rdata;
      mem_valid = vecs[i].valid;
      chk_ctl($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_iv, vecs[i].e_busy, vecs[i].e_err);
      if (vecs[i].c_addr) chk($sformatf("vec%0d.addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      if (vecs[i].c_instr) chk($sformatf("vec%0d.instr", i), instr, vecs[i].e_instr);
      step();
    end
    start = 1'b0; mem_valid = 1'b0;

    // Timeout after 15 un-acked FETCH cycles, then recovery from ERR.
    start = 1'b1; pc = 8'h30;
    step();
    start = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk_ctl($sformatf("to.wait%0d", i), 1'b1, 1'b0, 1'b1, 1'b0);
      step();
    end
    chk_ctl("to.err", 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    chk_ctl("to.hold", 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1; pc = 8'h20;
    step();
    start = 1'b0;
    feed4("to.recover", 8'h20, 32'h44332211);

    // 14 waits on one beat stays just short of timeout.
    start = 1'b1; pc = 8'h50;
    step();
    start = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk_ctl("w14.pre", 1'b1, 1'b0, 1'b1, 1'b0);
    feed4("w14", 8'h50, 32'hA3A2A1A0);

    // Reset after beat 1 abandons the fetch and clears instr.
    start = 1'b1; pc = 8'h60;
    step();
    start = 1'b0; mem_valid = 1'b1; mem_rdata = 8'hAA;
    step();
    mem_rdata = 8'hBB;
    step();
    mem_valid = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk_ctl("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid.addr", 32'(mem_addr), 32'h0);
    chk("rst_mid.instr", instr, 32'h0);
    step();
    chk_ctl("rst_mid.idle", 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1; pc = 8'h70;
    step();
    start = 1'b0;
    feed4("rst_mid.refetch", 8'h70, 32'h87654321);

    // BEATS=2, DWIDTH=16 build with start held high while busy.
    pulses = 0;
    start2 = 1'b1; pc2 = 8'h08;
    step();
    pc2 = 8'h90; valid2 = 1'b1; rdata2 = 16'h1234;
    chk("p2.addr0", 32'(addr2), 32'h08);
    chk("p2.req0", 32'(req2), 32'h1);
    step();
    rdata2 = 16'hABCD;
    chk("p2.addr1", 32'(addr2), 32'h09);
    chk("p2.busy1", 32'(busy2), 32'h1);
    step();
    valid2 = 1'b0;
    chk("p2.iv", 32'(iv2), 32'h1);
    chk("p2.instr", instr2, 32'hABCD1234);
    chk("p2.req_done", 32'(req2), 32'h0);
    if (iv2) pulses++;
    step();
    start2 = 1'b0;
    chk("p2.idle_busy", 32'(busy2), 32'h0);
    chk("p2.idle_req", 32'(req2), 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (iv2) pulses++;
      step();
    end
    chk("p2.pulses", 32'(pulses), 32'h1);
    chk("p2.instr_hold", instr2, 32'hABCD1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
